// File: rtl/seq_match_tracker.sv
// rtl/seq_match_tracker.sv - burst counter, run-length and error tracker behind the 0000/1111 detector
module seq_match_tracker #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             w,
    input  logic             z,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] one_cnt,
    output logic [RUN_W-1:0] cur_run,
    output logic [RUN_W-1:0] max_run,
    output logic             match_rise,
    output logic [1:0]       state,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MATCH0 = 2'b01,
        MATCH1 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t     fsm;
    logic       last_w;
    logic       has_last;
    logic       same_bit;
    logic [RUN_W-1:0] run_next;
    logic       run_short;

    assign state = fsm;

    // A run continues only when a previous sample exists and the bit repeats.
    always_comb begin
        same_bit = has_last && (w == last_w);
        run_next = RUN_ONE;
        if (same_bit) begin
            run_next = (cur_run == RUN_MAX) ? cur_run : cur_run + RUN_ONE;
        end
        run_short = (32'(run_next) < 32'd4);
    end

    always_ff @(posedge clock) begin
        if (!resetn || clr) begin
            fsm        <= IDLE;
            zero_cnt   <= '0;
            one_cnt    <= '0;
            cur_run    <= '0;
            max_run    <= '0;
            match_rise <= 1'b0;
            err        <= 1'b0;
            last_w     <= 1'b0;
            has_last   <= 1'b0;
        end else begin
            match_rise <= 1'b0;
            if (in_valid) begin
                cur_run  <= run_next;
                last_w   <= w;
                has_last <= 1'b1;
                if (run_next > max_run) begin
                    max_run <= run_next;
                end
                // A match indication on a run too short to be a match is a protocol error.
                if (z && run_short) begin
                    err <= 1'b1;
                end
                if (!z) begin
                    fsm <= IDLE;
                end else if (!w) begin
                    fsm <= MATCH0;
                    if (fsm != MATCH0) begin
                        match_rise <= 1'b1;
                        if (zero_cnt != CNT_MAX) begin
                            zero_cnt <= zero_cnt + 1'b1;
                        end
                    end
                end else begin
                    fsm <= MATCH1;
                    if (fsm != MATCH1) begin
                        match_rise <= 1'b1;
                        if (one_cnt != CNT_MAX) begin
                            one_cnt <= one_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_match_tracker.sv
// tb/tb_seq_match_tracker.sv - directed checks of seq_match_tracker at three parameterisations
module tb_seq_match_tracker;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic w = 1'b0;
    logic z = 1'b0;

    logic [7:0] d_zero_cnt, d_one_cnt;
    logic [5:0] d_cur_run, d_max_run;
    logic       d_match_rise, d_err;
    logic [1:0] d_state;

    logic [1:0] c_zero_cnt, c_one_cnt;
    logic [5:0] c_cur_run, c_max_run;
    logic       c_match_rise, c_err;
    logic [1:0] c_state;

    logic [7:0] r_zero_cnt, r_one_cnt;
    logic [2:0] r_cur_run, r_max_run;
    logic       r_match_rise, r_err;
    logic [1:0] r_state;

    int errors = 0;
    int checks = 0;
    int rise_c = 0;

    always #5 clock = ~clock;

    seq_match_tracker dut (
        .clock(clock), .resetn(resetn), .clr(clr), .in_valid(in_valid), .w(w), .z(z),
        .zero_cnt(d_zero_cnt), .one_cnt(d_one_cnt), .cur_run(d_cur_run), .max_run(d_max_run),
        .match_rise(d_match_rise), .state(d_state), .err(d_err)
    );

    seq_match_tracker #(.CNT_W(2), .RUN_W(6)) dut_c2 (
        .clock(clock), .resetn(resetn), .clr(clr), .in_valid(in_valid), .w(w), .z(z),
        .zero_cnt(c_zero_cnt), .one_cnt(c_one_cnt), .cur_run(c_cur_run), .max_run(c_max_run),
        .match_rise(c_match_rise), .state(c_state), .err(c_err)
    );

    seq_match_tracker #(.CNT_W(8), .RUN_W(3)) dut_r3 (
        .clock(clock), .resetn(resetn), .clr(clr), .in_valid(in_valid), .w(w), .z(z),
        .zero_cnt(r_zero_cnt), .one_cnt(r_one_cnt), .cur_run(r_cur_run), .max_run(r_max_run),
        .match_rise(r_match_rise), .state(r_state), .err(r_err)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic v, input logic wi, input logic zi, input logic c);
        @(negedge clock);
        in_valid = v;
        w        = wi;
        z        = zi;
        clr      = c;
        @(posedge clock);
        #1;
        if (c_match_rise) rise_c++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset held for two clocks
        resetn = 1'b0;
        idle();
        idle();
        chk("rst_zero_cnt", 32'(d_zero_cnt), 0);
        chk("rst_one_cnt", 32'(d_one_cnt), 0);
        chk("rst_cur_run", 32'(d_cur_run), 0);
        chk("rst_max_run", 32'(d_max_run), 0);
        chk("rst_state", 32'(d_state), 0);
        chk("rst_rise", 32'(d_match_rise), 0);
        chk("rst_err", 32'(d_err), 0);
        @(negedge clock);
        resetn = 1'b1;

        // Six zeros, z on samples 4..6
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("z1_cur_run", 32'(d_cur_run), 1);
        chk("z1_state", 32'(d_state), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("z3_rise", 32'(d_match_rise), 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("z4_rise", 32'(d_match_rise), 1);
        chk("z4_zero_cnt", 32'(d_zero_cnt), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("z5_rise", 32'(d_match_rise), 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("z6_zero_cnt", 32'(d_zero_cnt), 1);
        chk("z6_cur_run", 32'(d_cur_run), 6);
        chk("z6_max_run", 32'(d_max_run), 6);
        chk("z6_state", 32'(d_state), 1);
        chk("z6_rise", 32'(d_match_rise), 0);
        chk("z6_err", 32'(d_err), 0);

        // Four ones, z on sample 4
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("o1_cur_run", 32'(d_cur_run), 1);
        chk("o1_state", 32'(d_state), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("o4_one_cnt", 32'(d_one_cnt), 1);
        chk("o4_zero_cnt", 32'(d_zero_cnt), 1);
        chk("o4_cur_run", 32'(d_cur_run), 4);
        chk("o4_max_run", 32'(d_max_run), 6);
        chk("o4_state", 32'(d_state), 2);
        chk("o4_rise", 32'(d_match_rise), 1);
        idle();
        chk("hold_rise", 32'(d_match_rise), 0);
        chk("hold_cur_run", 32'(d_cur_run), 4);

        // Five separate 0000 bursts; the CNT_W=2 instance saturates at 3
        do_clr();
        rise_c = 0;
        for (int b = 0; b < 5; b++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_c2_zero_cnt", 32'(c_zero_cnt), 3);
        chk("sat_c2_rises", 32'(rise_c), 5);
        chk("sat_d_zero_cnt", 32'(d_zero_cnt), 5);
        chk("sat_err", 32'(d_err), 0);
        chk("sat_max_run", 32'(d_max_run), 4);

        // Short-run match sets err; clr with a valid sample discards it
        do_clr();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("err_err", 32'(d_err), 1);
        chk("err_one_cnt", 32'(d_one_cnt), 1);
        chk("err_state", 32'(d_state), 2);
        chk("err_cur_run", 32'(d_cur_run), 2);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_err", 32'(d_err), 0);
        chk("clr_one_cnt", 32'(d_one_cnt), 0);
        chk("clr_zero_cnt", 32'(d_zero_cnt), 0);
        chk("clr_cur_run", 32'(d_cur_run), 0);
        chk("clr_max_run", 32'(d_max_run), 0);
        chk("clr_state", 32'(d_state), 0);
        chk("clr_rise", 32'(d_match_rise), 0);

        // Gaps inside a run of five zeros
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_first_run", 32'(d_cur_run), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        chk("gap_hold_run", 32'(d_cur_run), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap_rise", 32'(d_match_rise), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap_cur_run", 32'(d_cur_run), 5);
        chk("gap_max_run", 32'(d_max_run), 5);
        chk("gap_zero_cnt", 32'(d_zero_cnt), 1);
        chk("gap_state", 32'(d_state), 1);
        chk("gap_err", 32'(d_err), 0);

        // Direct MATCH0 -> MATCH1 counts as a new burst (run of 1, so also an error)
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("x01_state", 32'(d_state), 2);
        chk("x01_one_cnt", 32'(d_one_cnt), 1);
        chk("x01_rise", 32'(d_match_rise), 1);
        chk("x01_err", 32'(d_err), 1);
        chk("x01_max_run", 32'(d_max_run), 5);

        // Run of ten ones; RUN_W=3 saturates at 7
        do_clr();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, (i >= 3) ? 1'b1 : 1'b0, 1'b0);
        end
        chk("run10_r3_cur", 32'(r_cur_run), 7);
        chk("run10_r3_max", 32'(r_max_run), 7);
        chk("run10_r3_one_cnt", 32'(r_one_cnt), 1);
        chk("run10_r3_err", 32'(r_err), 0);
        chk("run10_d_cur", 32'(d_cur_run), 10);
        chk("run10_d_one_cnt", 32'(d_one_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
